digit_scan_driver: RTL and testbench
====================================

// Module: digit_scan_driver
// PURPOSE
//  Time-multiplexed scan driver for a common-anode multi-digit 7-segment display.
//  Holds a packed multi-digit value and walks one digit slot at a time. Each slot
//  presents one 4-bit nibble on 'digit' to the sevenseg decoder and drives the
//  matching active-low digit enable.
//  New values are double-buffered and take effect only at a frame boundary (no tearing).
//  Optional leading-zero blanking; dead time between slots suppresses ghosting.
// PARAMETERS
//  NUM_DIGITS   4      number of digit slots (>=2)
//  REFRESH_DIV  50000  clk cycles per digit slot (>DEAD_CYCLES)
//  DEAD_CYCLES  2      cycles at slot start with all enables off (>=1)
//  BLANK_LZ     1      1 = suppress leading zeros; 0 = show every digit
// PORTS
//  clk         in   1              system clock, rising edge
//  rst_n       in   1              async active-low reset
//  load        in   1              strobe: capture 'value' into staging register
//  value       in   4*NUM_DIGITS   packed nibbles; [3:0] = digit 0 (least significant)
//  digit       out  4              current nibble to sevenseg decoder
//  digit_en_n  out  NUM_DIGITS     active-low one-hot digit enable
//  blank       out  1              1 = current slot suppressed (enables all high)
//  pending     out  1              staged value waiting for frame boundary
//  frame_done  out  1              1-cycle pulse at frame wrap
// BEHAVIOUR
//  Reset (async, rst_n=0): all registers cleared.
//   - prescaler=0, idx=0, staged=0, shown=0, pending=0
//   - digit=0, digit_en_n=all 1, blank=0, frame_done=0
//  Prescaler counts 0..REFRESH_DIV-1 and wraps.
//   - On wrap, idx advances 0..NUM_DIGITS-1 and wraps to 0.
//  All outputs are registers aligned to the (prescaler, idx) state.
//   - Cycle c after reset release: prescaler=c mod REFRESH_DIV, idx=(c/REFRESH_DIV) mod NUM_DIGITS.
//   - Enables are never combinational.
//  digit = shown[4*idx+:4]; passed through unmodified (hex 0-F).
//  Blanking: blank=1 for slot i>0 when BLANK_LZ=1 and nibbles NUM_DIGITS-1..i are all 0.
//   - Digit 0 is never blanked.
//  digit_en_n:
//   - All 1 while prescaler<DEAD_CYCLES or blank=1.
//   - Otherwise only bit idx is 0.
//  Frame wrap = edge where idx goes NUM_DIGITS-1 -> 0.
//   - frame_done=1 for exactly that cycle.
//   - If pending=1: shown<=staged and pending<=0.
//   - The first slot of the new frame shows the new value.
//  load=1: staged<=value and pending<=1.
//   - Repeated loads before a wrap overwrite staged; last value wins.
//  load coincident with a wrap:
//   - The swap uses the previous staged contents.
//   - The new value is captured into staged and pending stays/becomes 1.
//   - It is displayed at the following wrap.
//  Reset mid-frame: outputs return to reset values immediately; the staged value is lost.
// TESTING  (NUM_DIGITS=4, REFRESH_DIV=8, DEAD_CYCLES=2)
//  1 Assert rst_n=0 mid-slot -> same instant: digit_en_n=4'b1111, digit=0, blank=0, pending=0, frame_done=0.
//  2 load 16'h1234 at cycle 3 -> pending=1.
//    Wrap at cycle 32: frame_done=1, pending=0.
//    Cycles 34-39: digit=4, en_n=1110; cycles 42-47: digit=3, en_n=1101.
//  3 shown=16'h0050, BLANK_LZ=1 -> slots 3,2: blank=1, en_n=1111.
//    Slot 1: digit=5, en_n=1101. Slot 0: digit=0, en_n=1110.
//    16'h0000 -> only slot 0 is lit.
//  4 load 16'h1111 then 16'h2222 in the same frame -> no frame ever shows 1111; next frame shows 2222.
//  5 load 16'hABCD on a wrap cycle with pending=0 -> not shown this frame; pending=1; shown at the next wrap.
//  6 BLANK_LZ=0, value 16'h00F0 -> all four slots are enabled in turn; digit sequence 0,F,0,0.

Source files
------------

// File: rtl/digit_scan_if.sv
// digit_scan_if
//   Bundles the load/value input side and the registered display outputs of
//   digit_scan_driver. NUM_DIGITS must match the driver it is connected to.
//   Signals:
//     load        strobe: capture 'value' into the staging register
//     value       packed nibbles, [3:0] = digit 0 (least significant)
//     digit       current nibble for the 7-segment decoder
//     digit_en_n  active-low one-hot digit enable
//     blank       current slot suppressed (leading zero)
//     pending     staged value waiting for the next frame boundary
//     frame_done  one-cycle pulse in the first cycle of a new frame
//   Modports: master (value source / display consumer), slave (driver).
interface digit_scan_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    load;
  logic [4*NUM_DIGITS-1:0] value;
  logic [3:0]              digit;
  logic [NUM_DIGITS-1:0]   digit_en_n;
  logic                    blank;
  logic                    pending;
  logic                    frame_done;

  modport master (
    output load, value,
    input  digit, digit_en_n, blank, pending, frame_done
  );

  modport slave (
    input  load, value,
    output digit, digit_en_n, blank, pending, frame_done
  );
endinterface

// File: rtl/digit_scan_driver.sv
// digit_scan_driver
//   Time-multiplexed scan driver for a common-anode multi-digit 7-segment
//   display. A prescaler divides clk into digit slots; each slot presents one
//   nibble of the displayed value and pulls the matching enable low, after a
//   short dead time with every enable off to avoid ghosting. Loaded values are
//   staged and only swapped into the displayed register at a frame wrap, so a
//   frame never mixes two values. Leading zeros can optionally be blanked.
//   Ports:
//     clk    system clock, rising edge
//     rst_n  asynchronous active-low reset
//     bus    digit_scan_if.slave (load/value in, display outputs out)
//   Every output is a register whose value corresponds to the current
//   (prescaler, idx) state: it is computed from the next-state values, so the
//   outputs and the scan position change on the same edge.
module digit_scan_driver #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int DEAD_CYCLES = 2,
  parameter bit BLANK_LZ    = 1'b1
) (
  input logic          clk,
  input logic          rst_n,
  digit_scan_if.slave  bus
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int VAL_W = 4 * NUM_DIGITS;

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] DEAD_END = CNT_W'(DEAD_CYCLES);
  localparam logic [IDX_W-1:0] IDX_MAX  = IDX_W'(NUM_DIGITS - 1);

  // Scan position
  logic [CNT_W-1:0] prescaler_q, prescaler_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  // Double-buffered value
  logic [VAL_W-1:0] staged_q, staged_d;
  logic [VAL_W-1:0] shown_q, shown_d;
  logic             pending_q, pending_d;

  // Registered outputs
  logic [3:0]            digit_q, digit_d;
  logic [NUM_DIGITS-1:0] digit_en_n_q, digit_en_n_d;
  logic                  blank_q, blank_d;
  logic                  frame_done_q, frame_done_d;

  logic slot_end;
  logic wrap;
  logic zero_above;

  // Scan counters and the staging/display swap.
  // NOTE: every signal assigned in an always_comb gets a default at the top of
  // the block so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    slot_end    = (prescaler_q == CNT_MAX);
    wrap        = slot_end && (idx_q == IDX_MAX);
    prescaler_d = slot_end ? '0 : prescaler_q + 1'b1;
    idx_d       = idx_q;
    if (slot_end) begin
      idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
    end

    // The swap always takes the staged contents from before this edge, so a
    // load landing on the wrap edge is held for the following frame.
    shown_d = (wrap && pending_q) ? staged_q : shown_q;

    staged_d  = staged_q;
    pending_d = pending_q;
    if (wrap) begin
      pending_d = 1'b0;
    end
    if (bus.load) begin
      staged_d  = bus.value;
      pending_d = 1'b1;
    end

    frame_done_d = wrap;
  end

  // Output decode from the next state, so outputs are registered yet line up
  // with the scan position they describe.
  always_comb begin
    digit_d = 4'h0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_d == IDX_W'(i)) begin
        digit_d = shown_d[4*i +: 4];
      end
    end

    // Walk from the most significant slot downwards; a slot is a leading zero
    // when it and every slot above it hold 0. Slot 0 is never considered.
    zero_above = 1'b1;
    blank_d    = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      zero_above = zero_above && (shown_d[4*i +: 4] == 4'h0);
      if (BLANK_LZ && zero_above && (idx_d == IDX_W'(i))) begin
        blank_d = 1'b1;
      end
    end

    digit_en_n_d = '1;
    if ((prescaler_d >= DEAD_END) && !blank_d) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (idx_d == IDX_W'(i)) begin
          digit_en_n_d[i] = 1'b0;
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  // NOTE: the staging and display registers are plain flops and are cleared
  // by reset like the rest of the state; a reset deliberately discards any
  // staged value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler_q  <= '0;
      idx_q        <= '0;
      staged_q     <= '0;
      shown_q      <= '0;
      pending_q    <= 1'b0;
      digit_q      <= 4'h0;
      digit_en_n_q <= '1;
      blank_q      <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      prescaler_q  <= prescaler_d;
      idx_q        <= idx_d;
      staged_q     <= staged_d;
      shown_q      <= shown_d;
      pending_q    <= pending_d;
      digit_q      <= digit_d;
      digit_en_n_q <= digit_en_n_d;
      blank_q      <= blank_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.digit      = digit_q;
  assign bus.digit_en_n = digit_en_n_q;
  assign bus.blank      = blank_q;
  assign bus.pending    = pending_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_digit_scan_driver.sv
// tb_digit_scan_driver
//   Two drivers (NUM_DIGITS=4, REFRESH_DIV=8, DEAD_CYCLES=2) share clk/rst_n:
//   u_lz blanks leading zeros, u_nolz shows every digit. 'cyc' counts rising
//   edges since reset release; cycle N is observed at the falling edge after
//   the Nth edge, and inputs are changed right after that observation.
module tb_digit_scan_driver;

  logic clk;
  logic rst_n;

  digit_scan_if #(.NUM_DIGITS(4)) b1 ();
  digit_scan_if #(.NUM_DIGITS(4)) b2 ();

  digit_scan_driver #(
    .NUM_DIGITS(4), .REFRESH_DIV(8), .DEAD_CYCLES(2), .BLANK_LZ(1'b1)
  ) u_lz (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b1)
  );

  digit_scan_driver #(
    .NUM_DIGITS(4), .REFRESH_DIV(8), .DEAD_CYCLES(2), .BLANK_LZ(1'b0)
  ) u_nolz (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  // Scheduled loads: applied during cycle ld_* (sampled at the edge ending it)
  int          ld_a = -1, ld_b = -1, ld2 = -1;
  logic [15:0] val_a = '0, val_b = '0, val2 = '0;

  typedef struct {
    int         cyc;
    logic [3:0] digit;
    logic [3:0] en_n;
    logic       blank;
    logic       pending;
    logic       fd;
  } vec_t;

  vec_t tbl[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    else n_pass++;
  endtask

  task automatic check_b1(input string tag, input logic [3:0] d, input logic [3:0] en,
                          input logic bl, input logic pd, input logic fd);
    check({tag, ".digit"},      32'(b1.digit),      32'(d));
    check({tag, ".en_n"},       32'(b1.digit_en_n), 32'(en));
    check({tag, ".blank"},      32'(b1.blank),      32'(bl));
    check({tag, ".pending"},    32'(b1.pending),    32'(pd));
    check({tag, ".frame_done"}, 32'(b1.frame_done), 32'(fd));
  endtask

  task automatic check_b2(input string tag, input logic [3:0] d, input logic [3:0] en,
                          input logic bl);
    check({tag, ".nolz.digit"}, 32'(b2.digit),      32'(d));
    check({tag, ".nolz.en_n"},  32'(b2.digit_en_n), 32'(en));
    check({tag, ".nolz.blank"}, 32'(b2.blank),      32'(bl));
  endtask

  task automatic tick();
    b1.load = 1'b0;
    if (cyc == ld_a) begin b1.load = 1'b1; b1.value = val_a; end
    if (cyc == ld_b) begin b1.load = 1'b1; b1.value = val_b; end
    b2.load  = (cyc == ld2);
    b2.value = val2;
    @(posedge clk);
    @(negedge clk);
    cyc++;
    b1.load = 1'b0;
    b2.load = 1'b0;
  endtask

  task automatic run_to(input int target);
    if (target < cyc) check("run_to_order", 32'(cyc), 32'(target));
    while (cyc < target) tick();
  endtask

  task automatic do_reset();
    ld_a = -1; ld_b = -1; ld2 = -1;
    b1.load = 1'b0; b2.load = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic saw_one;
    rst_n = 1'b0;
    b1.load = 1'b0; b1.value = '0;
    b2.load = 1'b0; b2.value = '0;

    // cyc, digit, en_n, blank, pending, frame_done ; load 16'h1234 in cycle 3
    tbl[0]  = '{0,  4'h0, 4'b1111, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{2,  4'h0, 4'b1110, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{4,  4'h0, 4'b1110, 1'b0, 1'b1, 1'b0};
    tbl[3]  = '{10, 4'h0, 4'b1111, 1'b1, 1'b1, 1'b0};
    tbl[4]  = '{31, 4'h0, 4'b1111, 1'b1, 1'b1, 1'b0};
    tbl[5]  = '{32, 4'h4, 4'b1111, 1'b0, 1'b0, 1'b1};
    tbl[6]  = '{33, 4'h4, 4'b1111, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{34, 4'h4, 4'b1110, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{39, 4'h4, 4'b1110, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{40, 4'h3, 4'b1111, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{42, 4'h3, 4'b1101, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{50, 4'h2, 4'b1011, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{58, 4'h1, 4'b0111, 1'b0, 1'b0, 1'b0};

    // Load 0x1234, first frame blank-but-digit-0, second frame shows it
    do_reset();
    ld_a = 3; val_a = 16'h1234;
    for (int i = 0; i < 13; i++) begin
      run_to(tbl[i].cyc);
      check_b1($sformatf("tbl%0d", i), tbl[i].digit, tbl[i].en_n,
               tbl[i].blank, tbl[i].pending, tbl[i].fd);
    end

    // Leading-zero blanking (0x0050) and no blanking (0x00F0)
    do_reset();
    ld_a = 0; val_a = 16'h0050;
    ld2  = 0; val2  = 16'h00F0;
    run_to(2);  check_b1("lz_f0_s0", 4'h0, 4'b1110, 1'b0, 1'b1, 1'b0);
    run_to(10); check_b1("lz_f0_s1", 4'h0, 4'b1111, 1'b1, 1'b1, 1'b0);
                check_b2("lz_f0_s1", 4'h0, 4'b1101, 1'b0);
    run_to(26); check_b1("lz_f0_s3", 4'h0, 4'b1111, 1'b1, 1'b1, 1'b0);
    run_to(34); check_b1("lz_s0", 4'h0, 4'b1110, 1'b0, 1'b0, 1'b0);
                check_b2("nolz_s0", 4'h0, 4'b1110, 1'b0);
    run_to(42); check_b1("lz_s1", 4'h5, 4'b1101, 1'b0, 1'b0, 1'b0);
                check_b2("nolz_s1", 4'hF, 4'b1101, 1'b0);
    run_to(50); check_b1("lz_s2", 4'h0, 4'b1111, 1'b1, 1'b0, 1'b0);
                check_b2("nolz_s2", 4'h0, 4'b1011, 1'b0);
    run_to(58); check_b1("lz_s3", 4'h0, 4'b1111, 1'b1, 1'b0, 1'b0);
                check_b2("nolz_s3", 4'h0, 4'b0111, 1'b0);

    // Two loads in one frame: last value wins, the first is never displayed
    do_reset();
    ld_a = 5;  val_a = 16'h1111;
    ld_b = 20; val_b = 16'h2222;
    saw_one = 1'b0;
    while (cyc < 64) begin
      if (b1.digit == 4'h1) saw_one = 1'b1;
      if (cyc == 34 || cyc == 42 || cyc == 50 || cyc == 58)
        check($sformatf("last_wins_c%0d", cyc), 32'(b1.digit), 32'h2);
      tick();
    end
    check("never_1111", 32'(saw_one), 32'h0);

    // Load on the wrap edge: held for the following frame
    do_reset();
    ld_a = 31; val_a = 16'hABCD;
    run_to(32); check_b1("wrapld_c32", 4'h0, 4'b1111, 1'b0, 1'b1, 1'b1);
    run_to(34); check_b1("wrapld_c34", 4'h0, 4'b1110, 1'b0, 1'b1, 1'b0);
    run_to(42); check_b1("wrapld_c42", 4'h0, 4'b1111, 1'b1, 1'b1, 1'b0);
    run_to(63); check_b1("wrapld_c63", 4'h0, 4'b1111, 1'b1, 1'b1, 1'b0);
    run_to(64); check_b1("wrapld_c64", 4'hD, 4'b1111, 1'b0, 1'b0, 1'b1);
    run_to(66); check_b1("wrapld_c66", 4'hD, 4'b1110, 1'b0, 1'b0, 1'b0);
    run_to(74); check_b1("wrapld_c74", 4'hC, 4'b1101, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset mid-slot with a value staged
    ld_a = 75; val_a = 16'h5678;
    run_to(76); check_b1("pre_rst", 4'hC, 4'b1101, 1'b0, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_b1("async_rst", 4'h0, 4'b1111, 1'b0, 1'b0, 1'b0);
    check_b2("async_rst", 4'h0, 4'b1111, 1'b0);
    repeat (2) @(negedge clk);
    ld_a = -1; ld2 = -1;
    rst_n = 1'b1;
    cyc = 0;
    run_to(33); check_b1("staged_lost_c33", 4'h0, 4'b1111, 1'b0, 1'b0, 1'b0);
    run_to(34); check_b1("staged_lost_c34", 4'h0, 4'b1110, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
